// File: rtl/run_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : run_sequencer
// Description : Sequences one test run of a single-cycle CPU. From IDLE it
//               latches the start address, end address and expected result,
//               holds the CPU in reset for RESET_CYCLES cycles, then lets it
//               run. The run ends when the CPU PC reaches the end address,
//               or when the watchdog expires. FIN then emits a one-cycle done
//               pulse before the sequencer returns to IDLE.
//
// Ports       : CLK            in   single clock, rising edge
//               resetl         in   synchronous active-low reset
//               start          in   begin a run (sampled in IDLE only)
//               startpc_in     in   [63:0] program start address
//               endpc          in   [63:0] termination address
//               expected       in   [63:0] expected MemtoReg value
//               cpu_resetl     out  registered active-low CPU reset
//               cpu_startpc    out  [63:0] registered CPU start PC
//               cpu_currentpc  in   [63:0] CPU current PC
//               cpu_memtoreg   in   [63:0] CPU MemtoReg value
//               busy           out  high in RST, RUN and FIN
//               done           out  one-cycle completion pulse
//               pass           out  captured result matched expected
//               timeout        out  watchdog expired
//               result         out  [63:0] captured cpu_memtoreg
//               cycle_count    out  [15:0] RUN cycles of current/last run
//
// Revision    : 1.0 - initial release
// ============================================================================
module run_sequencer #(
    parameter int RESET_CYCLES = 2,    // 1..15
    parameter int WDOG_LIMIT   = 255   // 1..65535
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        start,
    input  logic [63:0] startpc_in,
    input  logic [63:0] endpc,
    input  logic [63:0] expected,
    output logic        cpu_resetl,
    output logic [63:0] cpu_startpc,
    input  logic [63:0] cpu_currentpc,
    input  logic [63:0] cpu_memtoreg,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [63:0] result,
    output logic [15:0] cycle_count
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RST  = 2'd1;
    localparam logic [1:0] c_RUN  = 2'd2;
    localparam logic [1:0] c_FIN  = 2'd3;

    // Last value of the reset counter before the CPU is released.
    localparam logic [3:0]  c_RST_LAST  = 4'(RESET_CYCLES - 1);
    // cycle_count value seen in the final RUN cycle the watchdog allows.
    localparam logic [15:0] c_WDOG_LAST = 16'(WDOG_LIMIT - 1);

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [3:0]  r_rst_cnt;
    logic [63:0] r_endpc;
    logic [63:0] r_expected;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    logic [1:0]  w_state_nxt;
    logic [3:0]  w_rst_cnt_nxt;
    logic [63:0] w_endpc_nxt;
    logic [63:0] w_expected_nxt;
    logic        w_cpu_resetl_nxt;
    logic [63:0] w_cpu_startpc_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic        w_pass_nxt;
    logic        w_timeout_nxt;
    logic [63:0] w_result_nxt;
    logic [15:0] w_cycle_count_nxt;

    // End-of-program and watchdog conditions, evaluated during RUN.
    logic w_at_end;
    logic w_wdog_hit;

    assign w_at_end   = (cpu_currentpc >= r_endpc);
    assign w_wdog_hit = (cycle_count == c_WDOG_LAST);

    always_comb begin
        w_state_nxt       = r_state;
        w_rst_cnt_nxt     = r_rst_cnt;
        w_endpc_nxt       = r_endpc;
        w_expected_nxt    = r_expected;
        w_cpu_resetl_nxt  = cpu_resetl;
        w_cpu_startpc_nxt = cpu_startpc;
        w_busy_nxt        = busy;
        w_done_nxt        = 1'b0;
        w_pass_nxt        = pass;
        w_timeout_nxt     = timeout;
        w_result_nxt      = result;
        w_cycle_count_nxt = cycle_count;

        case (r_state)
            c_IDLE: begin
                w_cpu_resetl_nxt = 1'b0;
                w_busy_nxt       = 1'b0;
                if (start) begin
                    w_cpu_startpc_nxt = startpc_in;
                    w_endpc_nxt       = endpc;
                    w_expected_nxt    = expected;
                    w_cycle_count_nxt = 16'd0;
                    w_pass_nxt        = 1'b0;
                    w_timeout_nxt     = 1'b0;
                    w_result_nxt      = 64'd0;
                    w_rst_cnt_nxt     = 4'd0;
                    w_busy_nxt        = 1'b1;
                    w_state_nxt       = c_RST;
                end
            end

            c_RST: begin
                // The CPU sees cpu_resetl low for RESET_CYCLES cycles here;
                // the release is registered on the edge that enters RUN.
                if (r_rst_cnt == c_RST_LAST) begin
                    w_cpu_resetl_nxt = 1'b1;
                    w_state_nxt      = c_RUN;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt + 4'd1;
                end
            end

            c_RUN: begin
                // The terminating cycle is counted as well.
                w_cycle_count_nxt = cycle_count + 16'd1;
                if (w_at_end) begin
                    // End detection wins over a simultaneous watchdog hit.
                    w_result_nxt     = cpu_memtoreg;
                    w_pass_nxt       = (cpu_memtoreg == r_expected);
                    w_cpu_resetl_nxt = 1'b0;
                    w_done_nxt       = 1'b1;
                    w_state_nxt      = c_FIN;
                end else if (w_wdog_hit) begin
                    w_timeout_nxt    = 1'b1;
                    w_pass_nxt       = 1'b0;
                    w_cpu_resetl_nxt = 1'b0;
                    w_done_nxt       = 1'b1;
                    w_state_nxt      = c_FIN;
                end
            end

            c_FIN: begin
                // done is high for the single cycle spent in FIN.
                w_cpu_resetl_nxt = 1'b0;
                w_busy_nxt       = 1'b0;
                w_state_nxt      = c_IDLE;
            end

            default: begin
                w_cpu_resetl_nxt = 1'b0;
                w_busy_nxt       = 1'b0;
                w_state_nxt      = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers; resetl forces IDLE from any state without a done pulse.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!resetl) begin
            r_state     <= c_IDLE;
            r_rst_cnt   <= 4'd0;
            r_endpc     <= 64'd0;
            r_expected  <= 64'd0;
            cpu_resetl  <= 1'b0;
            cpu_startpc <= 64'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            result      <= 64'd0;
            cycle_count <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_rst_cnt   <= w_rst_cnt_nxt;
            r_endpc     <= w_endpc_nxt;
            r_expected  <= w_expected_nxt;
            cpu_resetl  <= w_cpu_resetl_nxt;
            cpu_startpc <= w_cpu_startpc_nxt;
            busy        <= w_busy_nxt;
            done        <= w_done_nxt;
            pass        <= w_pass_nxt;
            timeout     <= w_timeout_nxt;
            result      <= w_result_nxt;
            cycle_count <= w_cycle_count_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_run_sequencer
// Description : Self-checking bench for run_sequencer with a simple CPU model
//               (PC loads start PC while in reset, otherwise +4 per cycle, or
//               stays put when stuck). Expected run outcomes are queued as
//               each run is issued and compared by a monitor on done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_run_sequencer;

    localparam int RESET_CYCLES = 2;
    localparam int WDOG_LIMIT   = 255;

    logic        CLK;
    logic        resetl;
    logic        start;
    logic [63:0] startpc_in;
    logic [63:0] endpc;
    logic [63:0] expected;
    logic        cpu_resetl;
    logic [63:0] cpu_startpc;
    logic [63:0] cpu_currentpc;
    logic [63:0] cpu_memtoreg;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [63:0] result;
    logic [15:0] cycle_count;

    run_sequencer #(
        .RESET_CYCLES(RESET_CYCLES),
        .WDOG_LIMIT  (WDOG_LIMIT)
    ) u_dut (
        .CLK          (CLK),
        .resetl       (resetl),
        .start        (start),
        .startpc_in   (startpc_in),
        .endpc        (endpc),
        .expected     (expected),
        .cpu_resetl   (cpu_resetl),
        .cpu_startpc  (cpu_startpc),
        .cpu_currentpc(cpu_currentpc),
        .cpu_memtoreg (cpu_memtoreg),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .timeout      (timeout),
        .result       (result),
        .cycle_count  (cycle_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // CPU model
    logic r_stuck;
    always @(posedge CLK) begin
        if (!cpu_resetl)  cpu_currentpc <= cpu_startpc;
        else if (!r_stuck) cpu_currentpc <= cpu_currentpc + 64'd4;
    end
    assign cpu_memtoreg = (cpu_currentpc == 64'h30) ? 64'hF : cpu_currentpc + 64'h1000;

    // Scoreboard
    typedef struct packed {
        logic        pass;
        logic        to;
        logic [63:0] res;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done   = 0;
    int   n_starts = 0;
    logic r_done_d = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares on every done pulse.
    always @(negedge CLK) begin
        exp_t e;
        if (done) begin
            n_done++;
            chk("done_single_cycle", {63'd0, r_done_d}, 64'd0);
            chk("pass_and_timeout_exclusive", {63'd0, pass & timeout}, 64'd0);
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("pass", {63'd0, pass}, {63'd0, e.pass});
                chk("timeout", {63'd0, timeout}, {63'd0, e.to});
                chk("result", result, e.res);
                chk("cycle_count", {48'd0, cycle_count}, {48'd0, e.cnt});
            end
        end
        r_done_d <= done;
    end

    // One run. With noise set, start is held high with junk operands for the
    // whole busy period (RST, RUN and FIN), which must be ignored.
    task automatic do_run(input logic [63:0] spc, input logic [63:0] epc, input logic [63:0] exv,
                          input logic e_pass, input logic e_to, input logic [63:0] e_res,
                          input logic [15:0] e_cnt, input logic noise);
        int k;
        sb_q.push_back('{pass: e_pass, to: e_to, res: e_res, cnt: e_cnt});
        n_starts++;
        @(negedge CLK);
        start = 1'b1; startpc_in = spc; endpc = epc; expected = exv;
        @(negedge CLK);
        start = 1'b0;
        if (noise) begin
            start = 1'b1; startpc_in = 64'h100; endpc = 64'h8; expected = 64'h99;
        end
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        chk("cpu_startpc_latched", cpu_startpc, spc);
        k = 0;
        while (!cpu_resetl && k < 20) begin
            @(negedge CLK);
            k++;
        end
        chk("reset_cycles_to_run", 64'(k), 64'(RESET_CYCLES));
        k = 0;
        while (busy && k < 2000) begin
            @(negedge CLK);
            k++;
        end
        chk("run_completes", {63'd0, busy}, 64'd0);
        start = 1'b0;
        @(negedge CLK);
        chk("idle_after_run", {63'd0, busy}, 64'd0);
        chk("cpu_startpc_held", cpu_startpc, spc);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        resetl = 1'b0; start = 1'b1; r_stuck = 1'b0;
        startpc_in = 64'h44; endpc = 64'h80; expected = 64'h5;
        repeat (3) @(negedge CLK);
        chk("rst_cpu_resetl", {63'd0, cpu_resetl}, 64'd0);
        chk("rst_cpu_startpc", cpu_startpc, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_pass", {63'd0, pass}, 64'd0);
        chk("rst_timeout", {63'd0, timeout}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_cycle_count", {48'd0, cycle_count}, 64'd0);
        resetl = 1'b1; start = 1'b0;
        repeat (2) @(negedge CLK);
        chk("start_during_reset_ignored", {63'd0, busy}, 64'd0);

        // Nominal, mismatch
        do_run(64'h0, 64'h30, 64'hF,  1'b1, 1'b0, 64'hF, 16'd13, 1'b0);
        do_run(64'h0, 64'h30, 64'h10, 1'b0, 1'b0, 64'hF, 16'd13, 1'b0);
        // Watchdog: PC stuck at 0x8, result cleared at start and not captured
        r_stuck = 1'b1;
        do_run(64'h8, 64'h1000, 64'h0, 1'b0, 1'b1, 64'h0, 16'd255, 1'b0);
        r_stuck = 1'b0;
        // Immediate end: memtoreg at PC 0x40 is 0x1040
        do_run(64'h40, 64'h30, 64'h1040, 1'b1, 1'b0, 64'h1040, 16'd1, 1'b0);
        // Starts during RST/RUN/FIN ignored
        do_run(64'h0, 64'h30, 64'hF, 1'b1, 1'b0, 64'hF, 16'd13, 1'b1);

        // Reset pulse mid-RUN
        r_stuck = 1'b1;
        @(negedge CLK);
        start = 1'b1; startpc_in = 64'h8; endpc = 64'h1000; expected = 64'h0;
        @(negedge CLK);
        start = 1'b0;
        repeat (10) @(negedge CLK);
        chk("midrun_busy", {63'd0, busy}, 64'd1);
        resetl = 1'b0;
        @(negedge CLK);
        resetl = 1'b1;
        chk("midrst_cpu_resetl", {63'd0, cpu_resetl}, 64'd0);
        chk("midrst_cpu_startpc", cpu_startpc, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_pass", {63'd0, pass}, 64'd0);
        chk("midrst_timeout", {63'd0, timeout}, 64'd0);
        chk("midrst_result", result, 64'd0);
        chk("midrst_cycle_count", {48'd0, cycle_count}, 64'd0);
        repeat (300) @(negedge CLK);
        chk("midrst_stays_idle", {63'd0, busy}, 64'd0);
        r_stuck = 1'b0;

        chk("done_count", 64'(n_done), 64'(n_starts));
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 Parameter: RESET_CYCLES, 2, number of cycles cpu_resetl is held low before a run; legal range 1..15.
REQ-002 Parameter: WDOG_LIMIT, 255, maximum RUN-state cycles before timeout; legal range 1..65535.
REQ-003 CLK  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 resetl  in  1  synchronous, active-low reset.
REQ-005 start  in  1  request to begin a run; sampled only in IDLE.
REQ-006 startpc_in  in  64  program start address; latched on an accepted start.
REQ-007 endpc  in  64  termination address; latched on an accepted start.
REQ-008 expected  in  64  expected MemtoReg value; latched on an accepted start.
REQ-009 cpu_resetl  out  1  registered active-low reset to the single-cycle CPU.
REQ-010 cpu_startpc  out  64  registered start PC to the CPU.
REQ-011 cpu_currentpc  in  64  CPU current PC.
REQ-012 cpu_memtoreg  in  64  CPU MemtoReg output.
REQ-013 busy  out  1  high in RST, RUN and FIN.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 pass  out  1  result matched expected; held until the next accepted start.
REQ-016 timeout  out  1  watchdog expired; held until the next accepted start.
REQ-017 result  out  64  captured cpu_memtoreg; held until the next accepted start.
REQ-018 cycle_count  out  16  count of RUN cycles in the current or last run.

Function
REQ-019 The FSM SHALL have four states: IDLE, RST, RUN, FIN; all outputs SHALL be registered.
REQ-020 IDLE: cpu_resetl=0 (CPU held in reset) and busy=0.
REQ-021 IDLE with start=1: the FSM SHALL latch startpc_in->cpu_startpc, and latch endpc and expected.
REQ-022 IDLE with start=1: the FSM SHALL clear cycle_count, pass, timeout and result, then go to RST on the next edge.
REQ-023 start outside IDLE (RST, RUN, FIN) SHALL be ignored with no side effects.
REQ-024 RST: cpu_resetl stays 0 for exactly RESET_CYCLES cycles (internal counter), then the FSM SHALL enter RUN with cpu_resetl=1 registered on the same edge.
REQ-025 RUN: each cycle cycle_count SHALL increment by 1, including the terminating cycle.
REQ-026 RUN end check: if cpu_currentpc >= latched endpc (unsigned 64-bit compare), the FSM SHALL capture result<=cpu_memtoreg and pass<=(cpu_memtoreg==latched expected), then go to FIN.
REQ-027 RUN watchdog: else if cycle_count==WDOG_LIMIT-1, timeout<=1 and pass<=0, then go to FIN.
REQ-028 End detection SHALL take priority over the watchdog in the same cycle.
REQ-029 FIN: done=1 for exactly one cycle and cpu_resetl<=0; the FSM SHALL then return to IDLE.
REQ-030 An accepted start SHALL reach the first RUN cycle after 1+RESET_CYCLES edges.
REQ-031 A run SHALL occupy at most WDOG_LIMIT RUN cycles.
REQ-032 pass and timeout SHALL never both be 1.
REQ-033 endpc <= startpc_in SHALL complete in the first RUN cycle with cycle_count=1.

Reset
REQ-034 With resetl=0 at an edge, the FSM SHALL go to IDLE from any state, including mid-RUN, with no done pulse.
REQ-035 Reset values SHALL be: cpu_resetl=0, cpu_startpc=0, busy=0, done=0, pass=0, timeout=0, result=0, cycle_count=0, and latched endpc/expected=0.
REQ-036 A start asserted while resetl=0 SHALL be ignored.

Verification
REQ-037 Nominal run, with the CPU model resetting PC to startpc while cpu_resetl=0 and otherwise adding 4 per cycle, and memtoreg=0xF at PC 0x30.
  - Stimulus: start, startpc_in=0, endpc=0x30, expected=0xF.
  - Required: one done pulse, pass=1, result=0xF, timeout=0, cycle_count=13.
REQ-038 Mismatch: same as REQ-037 but expected=0x10 -> pass=0, timeout=0, result=0xF, cycle_count=13.
REQ-039 Watchdog: CPU model PC stuck at 0x8, endpc=0x1000 -> after 255 RUN cycles, timeout=1, pass=0, cycle_count=255, one done pulse.
REQ-040 Immediate end: startpc_in=0x40, endpc=0x30 -> done with cycle_count=1, result=memtoreg at PC 0x40.
REQ-041 start pulsed in RST, RUN and FIN -> ignored; latched endpc/expected unchanged; exactly one done per accepted start.
REQ-042 resetl=0 for one cycle during RUN -> next cycle state IDLE, cpu_resetl=0, busy=0, done never asserted, all outputs at reset values.
